uvme_apb_st_slv_mem: RTL and testbench
======================================

Name: uvme_apb_st_slv_mem

Overview:
- Synthesizable APB slave with word-addressed memory, used as the responder in the APB self-test environment.
- Its bus port connects to the slave-side uvma_apb_if, so the environment checker observes the traffic it produces.
- Inserts programmable wait states and flags out-of-range or misaligned accesses with PSLVERR.
- Reports protocol misuse by the master on a pulse output.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; must be 32.
- MEM_DEPTH, 256, number of 32-bit words; power of two, 2..65536.

Ports:
- clk  in  1  single clock; everything samples on the rising edge.
- reset  in  1  reset; synchronous, active-high.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte strobes; used only with the optional feature.
- wait_cycles  in  4  wait states for the next transfer, sampled at the setup phase.
- prdata  out  DATA_WIDTH  read data; valid when pready=1 and pwrite=0.
- pready  out  1  transfer completion.
- pslverr  out  1  error response; valid only while pready=1.
- proto_err  out  1  one-cycle pulse on master protocol violation.
- xfer_cnt  out  16  completed transfers (OK or error), saturating at 0xFFFF.

Behaviour:
- Reset (sync, active-high, takes priority over all other logic):
  - state=IDLE; pready=0, pslverr=0, prdata=0, proto_err=0, xfer_cnt=0.
  - All memory words = 0.
  - Reset mid-transfer abandons it; no write, no count.
- FSM states: IDLE, ACCESS. All outputs are registered.
- IDLE:
  - psel=1, penable=0 (setup) → latch paddr, pwrite, pwdata, pstrb; load cnt=wait_cycles; go to ACCESS.
  - At the same edge, if wait_cycles==0: pready<=1 and prdata/pslverr are loaded.
  - psel=1, penable=1 → proto_err pulse; stay in IDLE.
- ACCESS with pready=0:
  - cnt decrements each edge.
  - When cnt==1 at an edge: pready<=1 and prdata/pslverr are loaded.
  - Wait time is therefore exactly wait_cycles access cycles before the pready cycle.
- ACCESS with pready=1 (completion edge, psel=1, penable=1):
  - Commit the write if pwrite=1 and no error.
  - xfer_cnt++ (saturating).
  - pready<=0, pslverr<=0, prdata<=0; go to IDLE.
  - Minimum transfer is 2 cycles, so back-to-back transfers are supported: the cycle after completion is IDLE and accepts the next setup.
- Error conditions (evaluated on the latched address):
  - paddr[1:0]!=0, or (paddr>>2) >= MEM_DEPTH.
  - Result: pslverr=1 with pready, prdata=0, write suppressed.
- Reads: prdata = mem[paddr>>2] as sampled when pready is set; a same-cycle write from another source is impossible (single port).
- Protocol violations, any of which gives a proto_err pulse:
  - In ACCESS, psel=0 or penable=0 → abort to IDLE; pready/pslverr/prdata cleared; no write, no count.
  - In ACCESS, paddr/pwrite/pwdata differ from the latched values → pulse only; the latched values are used.
- Index width: clog2(MEM_DEPTH). Upper address bits participate in the range check; no aliasing.

Optional Feature:
- Macro: UVME_APB_ST_SLV_MEM_PSTRB_EN.
- Defined: a write updates only bytes whose pstrb bit is 1. A read with pstrb!=0 raises proto_err but completes normally.
- Undefined: pstrb is ignored; every write updates the full word.

Decomposition:
- Package uvme_apb_st_slv_mem_pkg:
  - state enum (IDLE, ACCESS).
  - constant for the wait_cycles width (4).
  - constant XFER_CNT_MAX = 16'hFFFF.
- Sub-module uvme_apb_st_slv_mem_wait_ctr: loadable 4-bit down-counter with a "ready next edge" output. Wait counting is its only job.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wait_cycles=0, then read 0x10 → both transfers take 2 cycles; prdata=0xDEADBEEF; pslverr=0; xfer_cnt=2.
- Read 0x20 with wait_cycles=3 → pready rises on the 4th access cycle (transfer length 5 cycles); prdata=0.
- Write to 0x400 with MEM_DEPTH=256, then to 0x13 → pslverr=1 with pready on each; a read of 0x10 returns its prior value; xfer_cnt increments by 2.
- psel dropped in the second wait cycle of a wait_cycles=5 write to 0x8 → proto_err pulses once; FSM returns to IDLE; mem[2] unchanged; xfer_cnt unchanged.
- Assert reset during the ACCESS of a wait_cycles=2 write → all outputs 0 next cycle; memory all zero; a subsequent read returns 0.
- With PSTRB_EN, write 0x11223344 (pstrb=0xF) then 0xAABBCCDD (pstrb=0x5) to 0x0 → read returns 0x11BB33DD. Without the macro the same sequence returns 0xAABBCCDD.

Source files
------------

// File: rtl/uvme_apb_st_slv_mem_pkg.sv
// Shared types and constants for the APB self-test memory slave.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uvme_apb_st_slv_mem_pkg;

  // Transfer FSM: waiting for a setup phase, or inside the access phase
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Width of the programmable wait-state count
  localparam int WAIT_W = 4;

  // Completed-transfer counter stops here instead of wrapping
  localparam logic [15:0] XFER_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == XFER_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uvme_apb_st_slv_mem_if.sv
// APB bus bundle between the self-test master and the memory slave.
// Latency: none, wires only.
// Backpressure: slave stretches transfers by holding pready low.
interface uvme_apb_st_slv_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/uvme_apb_st_slv_mem_wait_ctr.sv
// Loadable wait-state down-counter; flags the edge at which pready should rise.
// Latency: ready_next is combinational from the registered count.
// Backpressure: none; counts only while dec is asserted.
module uvme_apb_st_slv_mem_wait_ctr
  import uvme_apb_st_slv_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              ready_next
);
  logic [WAIT_W-1:0] cnt;

  // Load at setup, then count down once per wait cycle, holding at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Last wait cycle: the next edge raises pready
  assign ready_next = (cnt == WAIT_W'(1));

endmodule

// File: rtl/uvme_apb_st_slv_mem.sv
// APB slave with word-addressed memory, programmable wait states, PSLVERR on bad addresses.
// Latency: 2 cycles minimum per transfer plus wait_cycles access cycles; all outputs registered.
// Backpressure: pready held low for wait_cycles access cycles; master aborts are flagged on proto_err.
// Optional byte-strobe writes are enabled by defining UVME_APB_ST_SLV_MEM_PSTRB_EN.
module uvme_apb_st_slv_mem
  import uvme_apb_st_slv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  uvme_apb_st_slv_mem_if.slave bus,
  input  logic [WAIT_W-1:0]    wait_cycles,
  output logic                 proto_err,
  output logic [15:0]          xfer_cnt
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [0:0] IDLE   = ST_IDLE;
  localparam logic [0:0] ACCESS = ST_ACCESS;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  setup_ph;
  logic                  access_ph;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_write;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [IDX_W-1:0]      lat_idx;
  logic                  mismatch;
  logic                  rd_strb_viol;
  logic                  ctr_load;
  logic                  ctr_dec;
  logic                  ready_next;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_word;

  // MEM_DEPTH is a power of two, so any address bit above the index field
  // means out of range; this also keeps high addresses from aliasing.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (|a[ADDR_WIDTH-1:IDX_W+2]);
  endfunction

  // Response data comes from the live bus in IDLE (zero-wait) or the latched copy in ACCESS
  always_comb begin
    setup_ph  = bus.psel && !bus.penable;
    access_ph = bus.psel && bus.penable;
    sel_addr  = (state == IDLE) ? bus.paddr  : lat_addr;
    sel_write = (state == IDLE) ? bus.pwrite : lat_write;
    sel_err   = addr_err(sel_addr);
    rsp_data  = (sel_err || sel_write) ? '0 : mem[sel_addr[IDX_W+1:2]];
    lat_idx   = lat_addr[IDX_W+1:2];
    mismatch  = (bus.paddr != lat_addr) || (bus.pwrite != lat_write) ||
                (bus.pwdata != lat_wdata);
    ctr_load  = (state == IDLE) && setup_ph;
    ctr_dec   = (state == ACCESS) && access_ph && !pready_q;
    wr_en     = (state == ACCESS) && access_ph && pready_q && lat_write && !pslverr_q;
  end

`ifdef UVME_APB_ST_SLV_MEM_PSTRB_EN
  logic [STRB_W-1:0] lat_strb;

  // Latch strobes alongside the rest of the setup-phase request
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_strb <= '0;
    end else if (ctr_load) begin
      lat_strb <= bus.pstrb;
    end
  end

  // Merge only the strobed bytes into the existing word
  always_comb begin
    wr_word = mem[lat_idx];
    for (int b = 0; b < STRB_W; b++) begin
      if (lat_strb[b]) begin
        wr_word[8*b +: 8] = lat_wdata[8*b +: 8];
      end
    end
  end

  assign rd_strb_viol = !bus.pwrite && (bus.pstrb != '0);
`else
  logic unused_pstrb;

  assign wr_word      = lat_wdata;
  assign rd_strb_viol = 1'b0;
  assign unused_pstrb = ^bus.pstrb;
`endif

  uvme_apb_st_slv_mem_wait_ctr u_wait_ctr (
    .clk        (clk),
    .reset      (reset),
    .load       (ctr_load),
    .load_val   (wait_cycles),
    .dec        (ctr_dec),
    .ready_next (ready_next)
  );

  // Transfer FSM: setup latch, wait-state stretch, completion, abort and misuse reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      proto_err <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          if (setup_ph) begin
            lat_addr  <= bus.paddr;
            lat_write <= bus.pwrite;
            lat_wdata <= bus.pwdata;
            state     <= ACCESS;
            if (rd_strb_viol) begin
              proto_err <= 1'b1;
            end
            if (wait_cycles == '0) begin
              pready_q  <= 1'b1;
              pslverr_q <= sel_err;
              prdata_q  <= rsp_data;
            end
          end else if (access_ph) begin
            proto_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (!access_ph) begin
            proto_err <= 1'b1;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            state     <= IDLE;
          end else begin
            if (mismatch) begin
              proto_err <= 1'b1;
            end
            if (pready_q) begin
              xfer_cnt  <= sat_inc16(xfer_cnt);
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              prdata_q  <= '0;
              state     <= IDLE;
            end else if (ready_next) begin
              pready_q  <= 1'b1;
              pslverr_q <= sel_err;
              prdata_q  <= rsp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: cleared by reset, written only on an error-free write completion
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[lat_idx] <= wr_word;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_uvme_apb_st_slv_mem.sv
// Directed bench for the APB memory slave: vector table plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_uvme_apb_st_slv_mem;
  import uvme_apb_st_slv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wait_cycles = 4'd0;
  logic        proto_err;
  logic [15:0] xfer_cnt;

  always #5 clk = ~clk;

  uvme_apb_st_slv_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  uvme_apb_st_slv_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .wait_cycles (wait_cycles),
    .proto_err   (proto_err),
    .xfer_cnt    (xfer_cnt)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  wt;
    int          exp_len;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

`ifdef UVME_APB_ST_SLV_MEM_PSTRB_EN
  localparam logic [31:0] STRB_EXP = 32'h11BB33DD;
`else
  localparam logic [31:0] STRB_EXP = 32'hAABBCCDD;
`endif

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   proto_pulses = 0;
  int   exp_proto = 0;
  int   exp_xfer = 0;

  always @(negedge clk) if (proto_err === 1'b1) proto_pulses++;

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [3:0] wt, input int len,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.wt = wt;
    v.exp_len = len; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Full transfer starting at the current cycle (setup), bounded wait for pready
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [3:0] wt,
                          output logic [31:0] rdata, output logic err, output int len);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
    bus.pwdata = wdata; bus.pstrb = strb; wait_cycles = wt;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    len = 2;
    while (bus.pready !== 1'b1 && len < 40) begin
      @(posedge clk); #1;
      len++;
    end
    rdata = bus.prdata;
    err   = bus.pslverr;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pstrb = 4'h0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    int          ln;
    apb_xfer(1'b0, addr, 32'h0, 4'h0, 4'd0, rd, er, ln);
    exp_xfer++;
    chk({nm, " rdata"}, rd, exp);
    chk({nm, " len"}, ln, 32'd2);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ln;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;

    //          wr    addr          wdata         strb  wt     len err rdata
    vecs.push_back(mk(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 4'd0,  2, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,        4'h0, 4'd0,  2, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 32'h0000_0020, 32'h0,        4'h0, 4'd3,  5, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_0400, 32'h12345678, 4'hF, 4'd0,  2, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_0013, 32'hCAFEF00D, 4'hF, 4'd1,  3, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,        4'h0, 4'd2,  4, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 32'h0000_0011, 32'h0,        4'h0, 4'd0,  2, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_03FC, 32'h0BADCAFE, 4'hF, 4'd4,  6, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_03FC, 32'h0,        4'h0, 4'd15, 17, 1'b0, 32'h0BADCAFE));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 32'h11223344, 4'hF, 4'd0,  2, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 32'hAABBCCDD, 4'h5, 4'd1,  3, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 32'h0,        4'h0, 4'd0,  2, 1'b0, STRB_EXP));
    vecs.push_back(mk(1'b0, 32'h0000_0400, 32'h0,        4'h0, 4'd0,  2, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 32'h8000_0010, 32'h0,        4'h0, 4'd0,  2, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 32'h8000_0000, 32'hFFFFFFFF, 4'hF, 4'd0,  2, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 32'h0,        4'h0, 4'd1,  3, 1'b0, STRB_EXP));

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset pready", {31'b0, bus.pready}, 32'h0);
    chk("reset pslverr", {31'b0, bus.pslverr}, 32'h0);
    chk("reset prdata", bus.prdata, 32'h0);
    chk("reset proto_err", {31'b0, proto_err}, 32'h0);
    chk("reset xfer_cnt", {16'b0, xfer_cnt}, 32'h0);

    // Table: back-to-back transfers
    foreach (vecs[i]) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].wt, rd, er, ln);
      exp_xfer++;
      chk($sformatf("v%0d len", i), ln, vecs[i].exp_len);
      chk($sformatf("v%0d pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      if (!vecs[i].wr) chk($sformatf("v%0d prdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d xfer_cnt", i), {16'b0, xfer_cnt}, exp_xfer);
      chk($sformatf("v%0d proto_cnt", i), proto_pulses, exp_proto);
    end

    // psel+penable while idle: one pulse, no transfer
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = 32'h10;
    @(posedge clk); #1;
    chk("idle_en proto_err", {31'b0, proto_err}, 32'h1);
    chk("idle_en pready", {31'b0, bus.pready}, 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge clk); #1;
    chk("idle_en proto_err clr", {31'b0, proto_err}, 32'h0);
    exp_proto++;

    // Address changes during access: pulse, latched address still written
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h30;
    bus.pwdata = 32'h99; bus.pstrb = 4'hF; wait_cycles = 4'd1;
    @(posedge clk); #1;
    bus.penable = 1'b1; bus.paddr = 32'h34;
    @(posedge clk); #1;
    chk("mism proto_err", {31'b0, proto_err}, 32'h1);
    chk("mism pready", {31'b0, bus.pready}, 32'h1);
    bus.paddr = 32'h30;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pstrb = 4'h0;
    chk("mism pready clr", {31'b0, bus.pready}, 32'h0);
    exp_proto++; exp_xfer++;
    rd_chk("mism rd30", 32'h30, 32'h99);
    rd_chk("mism rd34", 32'h34, 32'h0);

    // psel dropped in the second wait cycle of a wait_cycles=5 write
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h8;
    bus.pwdata = 32'h5A5A5A5A; bus.pstrb = 4'hF; wait_cycles = 4'd5;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pstrb = 4'h0;
    @(posedge clk); #1;
    chk("abort proto_err", {31'b0, proto_err}, 32'h1);
    chk("abort pready", {31'b0, bus.pready}, 32'h0);
    @(posedge clk); #1;
    chk("abort proto_err clr", {31'b0, proto_err}, 32'h0);
    chk("abort xfer_cnt", {16'b0, xfer_cnt}, exp_xfer);
    exp_proto++;
    rd_chk("abort rd8", 32'h8, 32'h0);

    // Reset during access of a wait_cycles=2 write
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h4;
    bus.pwdata = 32'hFFFFFFFF; bus.pstrb = 4'hF; wait_cycles = 4'd2;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pstrb = 4'h0;
    chk("rstmid pready", {31'b0, bus.pready}, 32'h0);
    chk("rstmid pslverr", {31'b0, bus.pslverr}, 32'h0);
    chk("rstmid prdata", bus.prdata, 32'h0);
    chk("rstmid proto_err", {31'b0, proto_err}, 32'h0);
    chk("rstmid xfer_cnt", {16'b0, xfer_cnt}, 32'h0);
    exp_xfer = 0;
    rd_chk("rstmid rd4", 32'h4, 32'h0);
    rd_chk("rstmid rd10", 32'h10, 32'h0);
    rd_chk("rstmid rd3fc", 32'h3FC, 32'h0);
    chk("rstmid xfer_cnt after", {16'b0, xfer_cnt}, exp_xfer);

    @(negedge clk); #1;
    chk("proto pulses total", proto_pulses, exp_proto);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

endmodule
